// File: rtl/div_seq.sv
// Iterative signed/unsigned 32-bit restoring divider; returns {remainder, quotient} for HI/LO.
// Latency: ready_o rises 33 cycles after the accept edge (2 cycles for a zero divisor).
// Backpressure: result is held in END while start_i stays high; stallreq_o holds EX until ready_o.
module div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_nx;

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic              sign1_q;
    logic              sign2_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              neg1;
    logic              neg2;
    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W-1:0] quo_nx;
    logic [DATA_W-1:0] rem_fix;
    logic [DATA_W-1:0] quo_fix;
    logic              last_step;
    logic              accept;

    // Operand magnitudes and signs; the most negative value maps to its unsigned magnitude.
    always_comb begin
        neg1 = signed_div_i & opdata1_i[DATA_W-1];
        neg2 = signed_div_i & opdata2_i[DATA_W-1];
        mag1 = neg1 ? (-opdata1_i) : opdata1_i;
        mag2 = neg2 ? (-opdata2_i) : opdata2_i;
    end

    // One restoring step: shift the dividend MSB into the remainder and try a subtract.
    always_comb begin
        trial     = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvs_q};
        quo_nx    = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
        rem_nx    = trial[DATA_W] ? {rem_q[DATA_W-2:0], quo_q[DATA_W-1]} : trial[DATA_W-1:0];
        quo_fix   = (sign1_q ^ sign2_q) ? (-quo_nx) : quo_nx;
        rem_fix   = sign1_q ? (-rem_nx) : rem_nx;
        last_step = (cnt_q == CNT_W'(DATA_W - 1));
        accept    = start_i & ~annul_i;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FREE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state_q;
        case (state_q)
            FREE: begin
                if (accept) begin
                    state_nx = (opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_nx = annul_i ? FREE : END;
            end
            ON: begin
                if (annul_i) begin
                    state_nx = FREE;
                end else if (last_step) begin
                    state_nx = END;
                end
            end
            END: begin
                if (!start_i) begin
                    state_nx = FREE;
                end
            end
            default: state_nx = FREE;
        endcase
    end

    // Datapath: operand latch, iteration, sign fix and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            cnt_q    <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    cnt_q    <= '0;
                    if (accept && (opdata2_i != '0)) begin
                        rem_q   <= '0;
                        quo_q   <= mag1;
                        dvs_q   <= mag2;
                        sign1_q <= neg1;
                        sign2_q <= neg2;
                    end
                end
                BYZERO: begin
                    result_o <= '0;
                    ready_o  <= ~annul_i;
                end
                ON: begin
                    if (annul_i) begin
                        cnt_q <= '0;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_step) begin
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

    // Stall EX while a request is pending and not yet answered; never during reset.
    assign stallreq_o = start_i & ~ready_o & ~annul_i & ~rst;

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative 32-bit divide sequencer for DIV/DIVU in the 5-stage pipeline.
- EX raises `start_i` with operands and holds the pipeline via `stallreq_o` while this block computes one quotient bit per cycle.
- It returns {remainder, quotient} to EX for the HI/LO write.
- `annul_i` lets the pipeline control cancel an in-flight divide, e.g. on flush.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- signed_div_i  in  1  1 = signed DIV, 0 = DIVU; sampled at start
- opdata1_i  in  DATA_W  dividend; sampled at start
- opdata2_i  in  DATA_W  divisor; sampled at start
- start_i  in  1  divide request; held by EX until the result is consumed
- annul_i  in  1  cancel the current operation
- result_o  out  2*DATA_W  {remainder[63:32] -> HI, quotient[31:0] -> LO}
- ready_o  out  1  result_o valid
- stallreq_o  out  1  pipeline stall request to the control unit

Behaviour:
- One clock, `clk`; reset is synchronous and active-high on `rst`.
- Reset: state=FREE, cnt=0, result_o=0, ready_o=0. Reset wins over every other input, including mid-operation.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, opdata2_i==0 -> BYZERO.
  - start_i=1, annul_i=0, divisor nonzero -> ON. At the same edge: latch operands (signed mode: latch the magnitudes of negative operands), latch both operand signs, partial remainder=0, cnt=0.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BYZERO:
  - Next edge -> END with result=0.
  - annul_i=1 -> FREE.
- ON, one restoring step per cycle:
  - {rem,quo} shift left 1 with the dividend MSB entering rem.
  - trial = rem - divisor magnitude, computed in DATA_W+1 bits.
  - If trial is non-negative: rem=trial, quotient LSB=1; else quotient LSB=0.
  - cnt increments each step.
  - On the edge completing step 32 (cnt reaches DATA_W): apply the sign fix, register result_o, go to END.
  - Signed sign fix: quotient is negated iff the operand signs differ; remainder takes the dividend's sign.
  - annul_i=1 in ON -> FREE, cnt=0, result discarded; ready_o never asserts.
- END:
  - ready_o=1; result_o holds steady.
  - Stays in END while start_i=1.
  - start_i=0 -> FREE; ready_o and result_o clear at that edge.
  - annul_i in END is ignored; the result is already committed.
- Latency: nonzero divisor gives ready_o first high in the 33rd cycle after the start-accept edge. Divide-by-zero gives ready_o high 2 cycles after the start edge.
- stallreq_o (combinational) = start_i & ~ready_o & ~annul_i. It is 0 during reset and in FREE when start_i=0.
- Width and arithmetic rules:
  - Two's-complement wrap everywhere. The signed 0x80000000 magnitude is taken as unsigned 0x80000000.
  - 0x80000000 / -1 signed yields q=0x80000000, r=0. No trap.
  - Divide-by-zero result is architecturally UNPREDICTABLE; this block defines it as all zeros.
- start_i with annul_i=1 in FREE: not accepted.
- Operand changes after the accept edge are ignored.

Test Plan:
- DIVU 100/7, start held -> stallreq_o=1 for 32 cycles; ready_o=1 at cycle 33; result_o=0x00000002_0000000E; drop start -> FREE with ready_o=0 next cycle.
- DIV -100/7 (0xFFFFFF9C, 0x00000007) -> result_o=0xFFFFFFFE_FFFFFFF2; also 100/-7 -> 0x00000002_FFFFFFF2.
- DIV 0x80000000/0xFFFFFFFF -> 0x00000000_80000000; DIVU 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
- Divisor 0 with start -> BYZERO then END; ready_o=1 two cycles after start; result_o=0.
- Annul: annul_i=1 at ON cycle 10 -> FREE next edge, ready_o never high, stallreq_o=0; new start (9/3) accepted the following cycle -> result 0x00000000_00000003 after 33 cycles.
- rst=1 at ON cycle 20 -> next edge FREE, result_o=0, ready_o=0; rst held with start_i=1 -> no acceptance until rst drops.
